// File: rtl/alu_md_control.sv
// ALU control for the RISC-V core: decodes ALUOp/Funct into a 4-bit Operation and
// executes base ops in one cycle and M-extension ops with an iterative multiplier/divider.
module alu_md_control #(
    parameter int WIDTH    = 64,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       ALUOp,
    input  logic [4:0]       Funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       Operation,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             illegal,
    input  logic             flush
);
    // state | meaning
    // IDLE  | waiting for start
    // MUL   | shift-add steps, then sign fix and result select
    // DIV   | restoring steps, then sign fix and result select
    // DONE  | one-cycle done pulse, result valid
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010,
                           OP_XOR  = 4'b0011, OP_SLL  = 4'b0100, OP_SRL  = 4'b0101,
                           OP_SUB  = 4'b0110, OP_SRA  = 4'b0111, OP_SLT  = 4'b1000,
                           OP_ILL  = 4'b1001, OP_MUL  = 4'b1010, OP_MULH = 4'b1011,
                           OP_DIV  = 4'b1100, OP_DIVU = 4'b1101, OP_REM  = 4'b1110,
                           OP_REMU = 4'b1111;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [3:0]           op_q, op_d;
    logic                 neg_q, neg_d, rneg_q, rneg_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 illegal_q, illegal_d;

    always_comb begin
        Operation = OP_ILL;
        case (ALUOp)
            2'b00: Operation = OP_ADD;
            2'b01: Operation = OP_SUB;
            2'b10: begin
                case (Funct)
                    5'b00000: Operation = OP_ADD;
                    5'b01000: Operation = OP_SUB;
                    5'b00111: Operation = OP_AND;
                    5'b00110: Operation = OP_OR;
                    5'b00100: Operation = OP_XOR;
                    5'b00001: Operation = OP_SLL;
                    5'b00101: Operation = OP_SRL;
                    5'b01101: Operation = OP_SRA;
                    5'b00010: Operation = OP_SLT;
                    5'b10000: if (ENABLE_M) Operation = OP_MUL;
                    5'b10001: if (ENABLE_M) Operation = OP_MULH;
                    5'b10100: if (ENABLE_M) Operation = OP_DIV;
                    5'b10101: if (ENABLE_M) Operation = OP_DIVU;
                    5'b10110: if (ENABLE_M) Operation = OP_REM;
                    5'b10111: if (ENABLE_M) Operation = OP_REMU;
                    default:  Operation = OP_ILL;
                endcase
            end
            default: Operation = OP_ILL;
        endcase
    end

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    assign shamt = b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (Operation)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_ADD: alu_res = a + b;
            OP_XOR: alu_res = a ^ b;
            OP_SLL: alu_res = a << shamt;
            OP_SRL: alu_res = a >> shamt;
            OP_SUB: alu_res = a - b;
            OP_SRA: alu_res = $signed(a) >>> shamt;
            OP_SLT: alu_res[0] = $signed(a) < $signed(b);
            default: alu_res = '0;
        endcase
    end

    logic             is_mul, is_div, is_rem_new, sgn_op, min_by_neg1;
    logic [WIDTH-1:0] mag_a, mag_b;
    assign is_mul      = (Operation == OP_MUL) || (Operation == OP_MULH);
    assign is_div      = (Operation[3:2] == 2'b11);
    assign is_rem_new  = (Operation == OP_REM) || (Operation == OP_REMU);
    assign sgn_op      = (Operation == OP_MULH) || (Operation == OP_DIV) || (Operation == OP_REM);
    assign mag_a       = (sgn_op && a[WIDTH-1]) ? -a : a;
    assign mag_b       = (sgn_op && b[WIDTH-1]) ? -b : b;
    assign min_by_neg1 = sgn_op && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

    // Multiplier: product accumulates in the upper half while the multiplier shifts out the bottom.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next, prod_fix;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign prod_fix = neg_q ? -acc_q : acc_q;

    // Divider: remainder in the upper half, dividend shifting into quotient in the lower half.
    logic [WIDTH:0]       div_sh;
    logic [WIDTH-1:0]     div_sub, quo_fix, rem_fix;
    logic                 div_ge, rem_sel;
    logic [2*WIDTH-1:0]   div_next;
    assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge   = div_sh >= {1'b0, opnd_q};
    assign div_sub  = div_sh[WIDTH-1:0] - opnd_q;
    assign div_next = {(div_ge ? div_sub : div_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    assign quo_fix  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign rem_sel  = (op_q == OP_REM) || (op_q == OP_REMU);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        op_d      = op_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    op_d      = Operation;
                    cnt_d     = CNT_INIT;
                    illegal_d = 1'b0;
                    state_d   = DONE;
                    if (Operation == OP_ILL) begin
                        result_d  = '0;
                        illegal_d = 1'b1;
                    end else if (is_mul) begin
                        acc_d   = {{WIDTH{1'b0}}, mag_b};
                        opnd_d  = mag_a;
                        neg_d   = (Operation == OP_MULH) && (a[WIDTH-1] ^ b[WIDTH-1]);
                        state_d = MUL;
                    end else if (is_div) begin
                        if (b == '0) begin
                            result_d = is_rem_new ? a : '1;
                        end else if (min_by_neg1) begin
                            result_d = is_rem_new ? '0 : a;
                        end else begin
                            acc_d   = {{WIDTH{1'b0}}, mag_a};
                            opnd_d  = mag_b;
                            neg_d   = sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                            rneg_d  = sgn_op && a[WIDTH-1];
                            state_d = DIV;
                        end
                    end else begin
                        result_d = alu_res;
                    end
                end
                MUL: begin
                    if (cnt_q != '0) begin
                        acc_d = mul_next;
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        result_d = (op_q == OP_MULH) ? prod_fix[2*WIDTH-1:WIDTH]
                                                     : prod_fix[WIDTH-1:0];
                        state_d  = DONE;
                    end
                end
                DIV: begin
                    if (cnt_q != '0) begin
                        acc_d = div_next;
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        result_d = rem_sel ? rem_fix : quo_fix;
                        state_d  = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign result  = result_q;
    assign illegal = illegal_q;
    assign done    = (state_q == DONE);
    assign busy    = (state_q == MUL) || (state_q == DIV);
endmodule

// File: tb/tb_alu_md_control.sv
// Directed bench for alu_md_control: decode sweep, table of single/multi-cycle ops,
// and hand-written busy/flush/reset sequences.
module tb_alu_md_control;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   ALUOp = 2'b00;
    logic [4:0]   Funct = 5'b0;
    logic [W-1:0] a = '0, b = '0;
    logic [3:0]   Operation, op0;
    logic [W-1:0] result, res0;
    logic         done, busy, illegal, done0, busy0, ill0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_md_control #(.WIDTH(W), .ENABLE_M(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUOp(ALUOp), .Funct(Funct),
        .a(a), .b(b), .Operation(Operation), .result(result), .done(done),
        .busy(busy), .illegal(illegal), .flush(flush));

    alu_md_control #(.WIDTH(W), .ENABLE_M(1'b0)) dut_nom (
        .clk(clk), .reset(reset), .start(1'b0), .ALUOp(ALUOp), .Funct(Funct),
        .a(a), .b(b), .Operation(op0), .result(res0), .done(done0),
        .busy(busy0), .illegal(ill0), .flush(1'b0));

    typedef struct {
        logic [1:0]   aluop;
        logic [4:0]   funct;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ill;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] op, input logic [4:0] f, input logic [W-1:0] va,
                                input logic [W-1:0] vb, input logic [W-1:0] r, input logic il,
                                input int l);
        vec_t v;
        v.aluop = op; v.funct = f; v.a = va; v.b = vb; v.res = r; v.ill = il; v.lat = l;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int lat0, output int lat, output int bcnt);
        lat = lat0;
        bcnt = 0;
        while (!done && lat < 200) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [4:0] f, input logic [W-1:0] ia,
                          input logic [W-1:0] ib, output int lat, output int bcnt);
        @(negedge clk);
        ALUOp = op; Funct = f; a = ia; b = ib; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1, lat, bcnt);
    endtask

    logic [3:0] dec_m[32];
    logic [3:0] dec_nom[32];

    initial begin
        int lat, bcnt, seen;
        localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
        localparam logic [W-1:0] ONES = '1;

        for (int i = 0; i < 32; i++) begin dec_m[i] = 4'b1001; dec_nom[i] = 4'b1001; end
        dec_m[0]  = 4'b0010; dec_m[8]  = 4'b0110; dec_m[7]  = 4'b0000; dec_m[6]  = 4'b0001;
        dec_m[4]  = 4'b0011; dec_m[1]  = 4'b0100; dec_m[5]  = 4'b0101; dec_m[13] = 4'b0111;
        dec_m[2]  = 4'b1000;
        for (int i = 0; i < 16; i++) dec_nom[i] = dec_m[i];
        dec_m[16] = 4'b1010; dec_m[17] = 4'b1011; dec_m[20] = 4'b1100; dec_m[21] = 4'b1101;
        dec_m[22] = 4'b1110; dec_m[23] = 4'b1111;

        //           ALUOp  Funct     a                        b                        result                   ill lat
        vecs.push_back(mk(2'b10, 5'b01000, 64'd5,                   64'd7,                   64'hFFFF_FFFF_FFFF_FFFE, 0, 1));
        vecs.push_back(mk(2'b10, 5'b01101, MIN,                     64'd4,                   64'hF800_0000_0000_0000, 0, 1));
        vecs.push_back(mk(2'b10, 5'b00000, 64'd1,                   64'd1,                   64'd2,                   0, 1));
        vecs.push_back(mk(2'b10, 5'b00111, 64'hF0F0,                64'h0FF0,                64'h00F0,                0, 1));
        vecs.push_back(mk(2'b10, 5'b00110, 64'hF0F0,                64'h0FF0,                64'hFFF0,                0, 1));
        vecs.push_back(mk(2'b10, 5'b00100, 64'hF0F0,                64'h0FF0,                64'hFF00,                0, 1));
        vecs.push_back(mk(2'b10, 5'b00001, 64'd1,                   64'd65,                  64'd2,                   0, 1));
        vecs.push_back(mk(2'b10, 5'b00101, MIN,                     64'd63,                  64'd1,                   0, 1));
        vecs.push_back(mk(2'b10, 5'b00010, ONES,                    64'd1,                   64'd1,                   0, 1));
        vecs.push_back(mk(2'b10, 5'b00010, 64'd1,                   ONES,                    64'd0,                   0, 1));
        vecs.push_back(mk(2'b00, 5'b10111, ONES,                    64'd1,                   64'd0,                   0, 1));
        vecs.push_back(mk(2'b01, 5'b00000, 64'd0,                   64'd1,                   ONES,                    0, 1));
        vecs.push_back(mk(2'b11, 5'b00000, 64'd3,                   64'd4,                   64'd0,                   1, 1));
        vecs.push_back(mk(2'b10, 5'b10010, 64'd3,                   64'd4,                   64'd0,                   1, 1));
        vecs.push_back(mk(2'b10, 5'b10000, 64'd6,                   64'd7,                   64'd42,                  0, 66));
        vecs.push_back(mk(2'b10, 5'b10001, 64'hFFFF_FFFF_FFFF_FFFD, 64'h4000_0000_0000_0000, ONES,                    0, 66));
        vecs.push_back(mk(2'b10, 5'b10001, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h3FFF_FFFF_FFFF_FFFF, 0, 66));
        vecs.push_back(mk(2'b10, 5'b10000, ONES,                    ONES,                    64'd1,                   0, 66));
        vecs.push_back(mk(2'b10, 5'b10100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFD, 0, 66));
        vecs.push_back(mk(2'b10, 5'b10110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                   ONES,                    0, 66));
        vecs.push_back(mk(2'b10, 5'b10101, 64'd100,                 64'd7,                   64'd14,                  0, 66));
        vecs.push_back(mk(2'b10, 5'b10111, 64'd100,                 64'd7,                   64'd2,                   0, 66));
        vecs.push_back(mk(2'b10, 5'b10101, 64'd55,                  64'd0,                   ONES,                    0, 1));
        vecs.push_back(mk(2'b10, 5'b10111, 64'd123,                 64'd0,                   64'd123,                 0, 1));
        vecs.push_back(mk(2'b10, 5'b10100, MIN,                     ONES,                    MIN,                     0, 1));
        vecs.push_back(mk(2'b10, 5'b10110, MIN,                     ONES,                    64'd0,                   0, 1));

        #1;
        chk("rst_result", result, '0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_illegal", {63'd0, illegal}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        ALUOp = 2'b10;
        for (int f = 0; f < 32; f++) begin
            Funct = 5'(f); #1;
            chk($sformatf("dec_m_%0d", f), {60'd0, Operation}, {60'd0, dec_m[f]});
            chk($sformatf("dec_nom_%0d", f), {60'd0, op0}, {60'd0, dec_nom[f]});
        end
        for (int f = 0; f < 32; f += 5) begin
            Funct = 5'(f);
            ALUOp = 2'b00; #1; chk("dec_aluop00", {60'd0, Operation}, 64'h2);
            ALUOp = 2'b01; #1; chk("dec_aluop01", {60'd0, Operation}, 64'h6);
            ALUOp = 2'b11; #1; chk("dec_aluop11", {60'd0, Operation}, 64'h9);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].aluop, vecs[i].funct, vecs[i].a, vecs[i].b, lat, bcnt);
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_illegal", i), {63'd0, illegal}, {63'd0, vecs[i].ill});
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'(vecs[i].lat - 1));
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
        end

        // start held into DONE is ignored
        @(negedge clk);
        ALUOp = 2'b10; Funct = 5'b00000; a = 64'd2; b = 64'd3; start = 1'b1;
        @(posedge clk); #1;
        chk("hold_first_done", {63'd0, done}, 64'd1);
        chk("hold_first_result", result, 64'd5);
        a = 64'd10; b = 64'd10;
        @(posedge clk); #1;
        chk("hold_done_ignored", {63'd0, done}, 64'd0);
        start = 1'b0;
        @(posedge clk); #1;
        chk("hold_no_done", {63'd0, done}, 64'd0);
        chk("hold_result_kept", result, 64'd5);

        // second start while busy is ignored
        @(negedge clk);
        ALUOp = 2'b10; Funct = 5'b10101; a = 64'd100; b = 64'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        Funct = 5'b10000; a = 64'd6; b = 64'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_during_restart", {63'd0, busy}, 64'd1);
        wait_done(4, lat, bcnt);
        chk("busy_ignore_result", result, 64'd14);
        chk("busy_ignore_latency", 64'(lat), 64'd66);
        @(posedge clk); #1;

        // flush mid-DIV
        @(negedge clk);
        Funct = 5'b10100; a = 64'hFFFF_FFFF_FFFF_FFF9; b = 64'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy_low", {63'd0, busy}, 64'd0);
        seen = 0;
        repeat (80) begin @(posedge clk); #1; if (done) seen++; end
        chk("flush_no_done", 64'(seen), 64'd0);
        chk("flush_result_kept", result, 64'd14);

        // flush beats start in the same cycle
        @(negedge clk);
        Funct = 5'b00000; a = 64'd3; b = 64'd4; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_prio_done", {63'd0, done}, 64'd0);
        chk("flush_prio_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        chk("flush_prio_result", result, 64'd14);
        run_op(2'b10, 5'b00000, 64'd1, 64'd1, lat, bcnt);
        chk("post_flush_result", result, 64'd2);
        chk("post_flush_latency", 64'(lat), 64'd1);
        @(posedge clk); #1;

        // asynchronous reset mid-MUL
        run_op(2'b11, 5'b00000, 64'd0, 64'd0, lat, bcnt);
        chk("pre_reset_illegal", {63'd0, illegal}, 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        ALUOp = 2'b10; Funct = 5'b10000; a = 64'd9; b = 64'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        chk("pre_reset_busy", {63'd0, busy}, 64'd1);
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        chk("async_rst_busy", {63'd0, busy}, 64'd0);
        chk("async_rst_done", {63'd0, done}, 64'd0);
        chk("async_rst_illegal", {63'd0, illegal}, 64'd0);
        chk("async_rst_result", result, 64'd0);
        @(negedge clk) reset = 1'b1;
        seen = 0;
        repeat (70) begin @(posedge clk); #1; if (done) seen++; end
        chk("rst_abandon_no_done", 64'(seen), 64'd0);
        run_op(2'b10, 5'b00000, 64'd1, 64'd1, lat, bcnt);
        chk("post_rst_result", result, 64'd2);
        chk("post_rst_latency", 64'(lat), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
